// File: rtl/float_classify_pipe.sv
// float_classify_pipe: one-stage ready/valid slice that classifies LANES floats per transfer
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data upstream handshake;
//        out_valid/out_ready downstream handshake with registered out_class (one-hot
//        {normal,qnan,snan,subnormal,zero,inf} per lane) and out_sign; sticky, nan_count and
//        sub_count accumulate over accepted transfers; clear_sticky zeroes them synchronously.
module float_classify_pipe #(
   parameter int EXPONENT_WIDTH = 8,
   parameter int MANTISSA_WIDTH = 23,
   parameter int LANES          = 4,
   parameter int COUNT_WIDTH    = 16
) (
   input  logic                                               clk,
   input  logic                                               rst_n,
   input  logic                                               in_valid,
   output logic                                               in_ready,
   input  logic [LANES*(EXPONENT_WIDTH+MANTISSA_WIDTH+1)-1:0] in_data,
   output logic                                               out_valid,
   input  logic                                               out_ready,
   output logic [LANES*6-1:0]                                 out_class,
   output logic [LANES-1:0]                                   out_sign,
   output logic [4:0]                                         sticky,
   input  logic                                               clear_sticky,
   output logic [COUNT_WIDTH-1:0]                             nan_count,
   output logic [COUNT_WIDTH-1:0]                             sub_count
);
   localparam int W  = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;
   localparam bit E4M3 = EXPONENT_WIDTH == 4 && MANTISSA_WIDTH == 3;
   localparam bit NO_SPECIAL = (EXPONENT_WIDTH == 2 && MANTISSA_WIDTH == 3) ||
                               (EXPONENT_WIDTH == 3 && MANTISSA_WIDTH == 2) ||
                               (EXPONENT_WIDTH == 2 && MANTISSA_WIDTH == 1);
   localparam int PW = $clog2(LANES + 1);
   // one spare bit above the wider operand so saturation can be detected from the carry
   localparam int SW = (COUNT_WIDTH > PW ? COUNT_WIDTH : PW) + 1;

   function automatic logic [5:0] classify(input logic [W-2:0] x);
      logic [EXPONENT_WIDTH-1:0] e;
      logic [MANTISSA_WIDTH-1:0] m;
      e = x[W-2:MANTISSA_WIDTH];
      m = x[MANTISSA_WIDTH-1:0];
      if (e == '0) return (m == '0) ? 6'b000010 : 6'b000100;
      // small FP formats spend the all-ones exponent on ordinary values
      if (!(&e) || NO_SPECIAL) return 6'b100000;
      // E4M3 keeps a single NaN code (S.1111.111) and has no infinity
      if (E4M3) return (&m) ? 6'b010000 : 6'b100000;
      return (m == '0) ? 6'b000001 : m[MANTISSA_WIDTH-1] ? 6'b010000 : 6'b001000;
   endfunction

   logic                   accept;
   logic [LANES*6-1:0]     cls;
   logic [LANES-1:0]       sgn;
   logic [4:0]             sticky_in;
   logic [PW-1:0]          nan_pop, sub_pop;
   logic [SW-1:0]          nan_sum, sub_sum;
   logic [COUNT_WIDTH-1:0] nan_next, sub_next;

   assign in_ready = ~out_valid | out_ready;
   assign accept   = in_valid & in_ready;

   always_comb begin
      cls       = '0;
      sgn       = '0;
      sticky_in = '0;
      nan_pop   = '0;
      sub_pop   = '0;
      for (int i = 0; i < LANES; i++) begin
         cls[i*6 +: 6] = classify(in_data[i*W +: W-1]);
         sgn[i]        = in_data[i*W + W-1];
         sticky_in     = sticky_in | cls[i*6 +: 5];
         nan_pop       = nan_pop + PW'(cls[i*6+4] | cls[i*6+3]);
         sub_pop       = sub_pop + PW'(cls[i*6+2]);
      end
      // clear takes effect before the new transfer is added
      nan_sum  = (clear_sticky ? '0 : SW'(nan_count)) + (accept ? SW'(nan_pop) : '0);
      sub_sum  = (clear_sticky ? '0 : SW'(sub_count)) + (accept ? SW'(sub_pop) : '0);
      nan_next = (nan_sum[SW-1:COUNT_WIDTH] != '0) ? '1 : nan_sum[COUNT_WIDTH-1:0];
      sub_next = (sub_sum[SW-1:COUNT_WIDTH] != '0) ? '1 : sub_sum[COUNT_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_class <= '0;
         out_sign  <= '0;
         sticky    <= '0;
         nan_count <= '0;
         sub_count <= '0;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            out_class <= cls;
            out_sign  <= sgn;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         sticky    <= (clear_sticky ? 5'b0 : sticky) | (accept ? sticky_in : 5'b0);
         nan_count <= nan_next;
         sub_count <= sub_next;
      end
   end
endmodule

// File: doc/float_classify_pipe.md
FLOAT_CLASSIFY_PIPE -- requirements
Module: float_classify_pipe

Interface
REQ-001 Parameter EXPONENT_WIDTH, default 8: exponent field width, 2 or more.
REQ-002 Parameter MANTISSA_WIDTH, default 23: mantissa field width, 1 or more.
REQ-003 Parameter LANES, default 4: operands classified per transfer, 1 or more.
REQ-004 Parameter COUNT_WIDTH, default 16: width of each event counter.
REQ-005 Localparam W = EXPONENT_WIDTH+MANTISSA_WIDTH+1 SHALL be the operand width, laid out {sign, exponent, mantissa}.
REQ-006 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-007 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 Port in_valid, input, 1 bit: in_data is valid.
REQ-009 Port in_ready, output, 1 bit: the block can accept in_data.
REQ-010 Port in_data, input, LANES*W bits: lane i occupies bits [i*W +: W].
REQ-011 Port out_valid, output, 1 bit: out_class and out_sign are valid.
REQ-012 Port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-013 Port out_class, output, LANES*6 bits: per-lane one-hot class {normal, qnan, snan, subnormal, zero, inf}, with lane i at [i*6 +: 6] and inf as bit 0.
REQ-014 Port out_sign, output, LANES bits: registered sign of each lane.
REQ-015 Port sticky, output, 5 bits: accumulated OR of {qnan, snan, subnormal, zero, inf} over all lanes of every accepted transfer.
REQ-016 Port clear_sticky, input, 1 bit: synchronous clear of sticky and both counters.
REQ-017 Port nan_count, output, COUNT_WIDTH bits: saturating count of accepted NaN lanes, quiet plus signalling.
REQ-018 Port sub_count, output, COUNT_WIDTH bits: saturating count of accepted subnormal lanes.

Function
REQ-019 Accept SHALL equal in_valid AND in_ready; emit SHALL equal out_valid AND out_ready.
REQ-020 in_ready SHALL equal (NOT out_valid) OR out_ready, giving a single-register slice with full throughput and a combinational ready path.
REQ-021 On accept, out_class and out_sign SHALL load in the next cycle and out_valid SHALL be 1; latency is exactly 1 cycle.
REQ-022 On emit without accept, out_valid SHALL go to 0; while out_valid=1 and out_ready=0, out_class and out_sign SHALL hold stable.
REQ-023 Classification for IEEE-style formats, applied per lane with E = exponent and M = mantissa:
  - inf: E all-ones and M=0.
  - qnan: E all-ones and M MSB=1.
  - snan: E all-ones, M MSB=0, and M not equal to 0.
  - zero: E=0 and M=0.
  - subnormal: E=0 and M not equal to 0.
  - normal: any other encoding.
REQ-024 For E4M3 (4,3), NaN SHALL be only E=1111 with M=111, classed qnan, with no inf and no snan; E=1111 with any other M SHALL be normal.
REQ-025 For E2M3, E3M2 and E2M1, inf, qnan and snan SHALL never assert, and E all-ones SHALL be normal.
REQ-026 Exactly one out_class bit per lane SHALL be set whenever out_valid=1.
REQ-027 On each accept, sticky SHALL be OR-updated from that transfer's classes.
REQ-028 On each accept, each counter SHALL add that transfer's popcount (0..LANES) and saturate at all-ones without wrapping.
REQ-029 clear_sticky coinciding with an accept SHALL clear first and then apply the accept, so the result reflects only the new transfer.
REQ-030 Sticky and the counters SHALL change only on accept or clear_sticky, never on emit.

Reset
REQ-031 While rst_n=0, asynchronously: out_valid=0, out_class=0, out_sign=0, sticky=0, nan_count=0, sub_count=0.
REQ-032 in_ready SHALL be 1 during and immediately after reset.
REQ-033 Reset asserted mid-stream SHALL discard the held result with no partial output.
REQ-034 Deassertion is synchronised externally, so the block needs no internal synchroniser.

Verification
REQ-035 Defaults, one lane = 0x7FC00000 -> next cycle lane class = qnan (bit 4), sign 0; sticky = 5'b10000; nan_count +1.
REQ-036 Defaults, lanes {0x7F800001, 0xFF800000, 0x00000001, 0x80000000} -> classes snan, inf, subnormal, zero; out_sign = 4'b1010; sticky = 5'b01111.
REQ-037 E4M3, 8'h7F -> qnan; 8'h7E -> normal; 8'h00 -> zero; no inf ever seen.
REQ-038 out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, output stable, one accept only; then out_ready=1 -> back-to-back transfers at 1 per cycle.
REQ-039 COUNT_WIDTH=3, 3 transfers of 4 NaN lanes -> nan_count saturates at 7; clear_sticky in the same cycle as a 2-NaN accept -> nan_count=2.
REQ-040 rst_n pulsed low while out_valid=1 -> all outputs 0 immediately, without waiting for a clock edge.
